// File: rtl/timer_apb_pkg.sv
// Shared types and constants for the timer APB master: FSM states, default
// geometry and the word-alignment rule applied to incoming commands.
package timer_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int DEFAULT_ADDR_W      = 12;
    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_TIMEOUT_CYC = 16;

    // Wide enough for the largest supported timeout limit (255).
    localparam int CNT_W = 8;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting for pready; expired fires on the wait
// cycle whose increment would reach the limit, so the FSM can leave that edge.
module apb_timeout_cnt
    import timer_apb_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_inc;
        end
    end

    assign expired = enable && !clear && (cnt_inc == limit);

    // NOTE: clocked state uses non-blocking assignments only; the reset is
    // sampled on the clock edge, not in the sensitivity list.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_apb_master.sv
// Single-outstanding command-to-APB bridge: latches one command, runs the
// SETUP/ACCESS handshake with a wait-state timeout, and holds a response.
module timer_apb_master
    import timer_apb_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                tim_psel,
    output logic                tim_penable,
    output logic                tim_pwrite,
    output logic [ADDR_W-1:0]   tim_paddr,
    output logic [DATA_W-1:0]   tim_pwdata,
    output logic [DATA_W/8-1:0] tim_pstrb,
    input  logic [DATA_W-1:0]   tim_prdata,
    input  logic                tim_pready,
    input  logic                tim_pslverr
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q,       state_d;
    logic                cmd_ready_q,   cmd_ready_d;
    logic                psel_q,        psel_d;
    logic                penable_q,     penable_d;
    logic                pwrite_q,      pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,       paddr_d;
    logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
    logic [STRB_W-1:0]   pstrb_q,       pstrb_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                rsp_err_q,     rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_expired;

    assign cnt_clear = (state_q == SETUP);
    assign cnt_en    = (state_q == ACCESS) && !tim_pready;

    apb_timeout_cnt u_timeout_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .limit   (CNT_W'(TIMEOUT_CYC)),
        .expired (cnt_expired)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can infer a latch.
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                    pstrb_d     = cmd_write ? cmd_strb  : '0;
                    if (is_misaligned(cmd_addr[1:0])) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // A ready on the would-be expiry cycle wins over the timeout.
                if (tim_pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = tim_pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !tim_pslverr) ? tim_prdata : '0;
                end else if (cnt_expired) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    cmd_ready_d   = 1'b1;
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign tim_psel    = psel_q;
    assign tim_penable = penable_q;
    assign tim_pwrite  = pwrite_q;
    assign tim_paddr   = paddr_q;
    assign tim_pwdata  = pwdata_q;
    assign tim_pstrb   = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_timer_apb_master.sv
// Directed bench: each transaction is expanded into a per-cycle schedule of
// inputs and expected outputs, replayed and compared; literal pins close it out.
module tb_timer_apb_master;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 32;
    localparam int STRB_W      = DATA_W / 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int MAX_TXN     = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic              tim_psel, tim_penable, tim_pwrite;
    logic [ADDR_W-1:0] tim_paddr;
    logic [DATA_W-1:0] tim_pwdata, tim_prdata;
    logic [STRB_W-1:0] tim_pstrb;
    logic              tim_pready, tim_pslverr;

    always #5 sys_clk = ~sys_clk;

    timer_apb_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_pwrite  (tim_pwrite),
        .tim_paddr   (tim_paddr),
        .tim_pwdata  (tim_pwdata),
        .tim_pstrb   (tim_pstrb),
        .tim_prdata  (tim_prdata),
        .tim_pready  (tim_pready),
        .tim_pslverr (tim_pslverr)
    );

    typedef enum int {PH_RST, PH_ACCEPT, PH_SETUP, PH_ACCESS, PH_RESP, PH_ABORT, PH_IDLE} phase_e;

    // One schedule entry = one clock cycle: inputs sampled at the closing
    // edge, expectations for the outputs visible during the cycle.
    typedef struct {
        phase_e            ph;
        int                txn;
        bit                chk;
        bit                zero;
        bit                rst, cmd_valid, cmd_write, rsp_ready, pready, pslverr;
        logic [ADDR_W-1:0] cmd_addr;
        logic [DATA_W-1:0] cmd_wdata;
        logic [STRB_W-1:0] cmd_strb;
        logic [DATA_W-1:0] prdata;
        bit                x_cmd_ready, x_psel, x_penable, x_rsp_valid;
        bit                x_apb, x_pwrite, x_rsp, x_err, x_timeout;
        logic [ADDR_W-1:0] x_paddr;
        logic [DATA_W-1:0] x_pwdata, x_rdata;
        logic [STRB_W-1:0] x_pstrb;
    } cyc_t;

    cyc_t sched[$];
    int   txn_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int          accept_idx[MAX_TXN];
    int          psel_n[MAX_TXN], pen_n[MAX_TXN], rsp_n[MAX_TXN], first_rsp[MAX_TXN];
    logic        obs_err[MAX_TXN], obs_to[MAX_TXN];
    logic [31:0] obs_rdata[MAX_TXN];

    task automatic check(input string name, input int entry, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @entry %0d: got 0x%0h, expected 0x%0h", name, entry, act, exp);
        end
    endtask

    function automatic cyc_t blank(input phase_e ph, input int txn);
        cyc_t c;
        c.ph = ph;           c.txn = txn;          c.chk = 1'b1;        c.zero = 1'b0;
        c.rst = 1'b0;        c.cmd_valid = 1'b0;   c.cmd_write = 1'b0;  c.rsp_ready = 1'b0;
        c.pready = 1'b0;     c.pslverr = 1'b0;     c.cmd_addr = '0;     c.cmd_wdata = '0;
        c.cmd_strb = '0;     c.prdata = '0;
        c.x_cmd_ready = 1'b0; c.x_psel = 1'b0;     c.x_penable = 1'b0;  c.x_rsp_valid = 1'b0;
        c.x_apb = 1'b0;      c.x_pwrite = 1'b0;    c.x_rsp = 1'b0;      c.x_err = 1'b0;
        c.x_timeout = 1'b0;  c.x_paddr = '0;       c.x_pwdata = '0;     c.x_rdata = '0;
        c.x_pstrb = '0;
        return c;
    endfunction

    // Non-IDLE cycle: command inputs carry junk that must not disturb the
    // latched transfer; cmd_valid optionally stays high to prove no acceptance.
    function automatic cyc_t busy(input phase_e ph, input int txn, input bit wr,
                                  input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                  input logic [STRB_W-1:0] strb, input bit hv);
        cyc_t c;
        c = blank(ph, txn);
        c.cmd_valid = hv;
        c.cmd_write = ~wr;
        c.cmd_addr  = addr ^ ADDR_W'(12'h0F0);
        c.cmd_wdata = ~wdata;
        c.cmd_strb  = ~strb;
        return c;
    endfunction

    // waits = pready-low cycles before ready; >= TIMEOUT_CYC means never ready.
    // abort_at = ACCESS cycle number (1-based) in which reset is asserted, 0 = none.
    task automatic add_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input logic [STRB_W-1:0] strb, input int waits, input bit slverr,
                           input logic [DATA_W-1:0] rdata, input int rsp_hold, input int abort_at,
                           input bit hv);
        cyc_t              c;
        int                id;
        int                n_acc;
        bit                mis, timed_out, err;
        logic [DATA_W-1:0] x_pw, x_rd;
        logic [STRB_W-1:0] x_ps;

        id        = txn_cnt;
        txn_cnt++;
        mis       = (int'(addr) % 4) != 0;
        x_pw      = wr ? wdata : '0;
        x_ps      = wr ? strb : '0;
        timed_out = 1'b0;

        accept_idx[id] = sched.size();
        c = blank(PH_ACCEPT, id);
        c.cmd_valid = 1'b1;  c.cmd_write = wr;  c.cmd_addr = addr;
        c.cmd_wdata = wdata; c.cmd_strb = strb; c.x_cmd_ready = 1'b1;
        sched.push_back(c);

        if (!mis) begin
            c = busy(PH_SETUP, id, wr, addr, wdata, strb, hv);
            c.pready = 1'b1;
            c.x_psel = 1'b1;   c.x_apb = 1'b1;     c.x_pwrite = wr;
            c.x_paddr = addr;  c.x_pwdata = x_pw;  c.x_pstrb = x_ps;
            sched.push_back(c);

            timed_out = (waits >= TIMEOUT_CYC);
            n_acc     = timed_out ? TIMEOUT_CYC : waits + 1;
            for (int k = 1; k <= n_acc; k++) begin
                c = busy(PH_ACCESS, id, wr, addr, wdata, strb, hv);
                c.pready  = (k == waits + 1);
                c.pslverr = c.pready ? slverr : 1'b1;
                c.prdata  = c.pready ? rdata : DATA_W'(32'hDEAD_0000 + k);
                c.x_psel  = 1'b1;  c.x_penable = 1'b1;  c.x_apb = 1'b1;  c.x_pwrite = wr;
                c.x_paddr = addr;  c.x_pwdata = x_pw;   c.x_pstrb = x_ps;
                if (k == abort_at) begin
                    c.rst = 1'b1;
                    sched.push_back(c);
                    c = blank(PH_ABORT, id);
                    c.zero = 1'b1;
                    sched.push_back(c);
                    return;
                end
                sched.push_back(c);
            end
        end

        err  = mis || timed_out || slverr;
        x_rd = (!wr && !err) ? rdata : '0;
        for (int h = 0; h <= rsp_hold; h++) begin
            c = busy(PH_RESP, id, wr, addr, wdata, strb, hv);
            c.pready = 1'b1;  c.pslverr = 1'b1;  c.rsp_ready = (h == rsp_hold);
            c.x_rsp_valid = 1'b1;  c.x_rsp = 1'b1;  c.x_err = err;
            c.x_timeout = timed_out;  c.x_rdata = x_rd;
            sched.push_back(c);
        end
    endtask

    task automatic add_idle(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank(PH_IDLE, -1);
            c.x_cmd_ready = 1'b1;
            sched.push_back(c);
        end
    endtask

    task automatic add_power_on_reset();
        cyc_t c;
        c = blank(PH_RST, -1);  c.rst = 1'b1;  c.chk = 1'b0;  sched.push_back(c);
        c = blank(PH_RST, -1);  c.rst = 1'b1;  c.zero = 1'b1; sched.push_back(c);
        c = blank(PH_RST, -1);  c.rst = 1'b0;  c.zero = 1'b1; sched.push_back(c);
    endtask

    task automatic play();
        cyc_t c;
        for (int i = 0; i < sched.size(); i++) begin
            @(negedge sys_clk);
            c = sched[i];
            if (c.chk) begin
                if (c.zero) begin
                    check("zero_ctl", i, 64'({cmd_ready, tim_psel, tim_penable, tim_pwrite,
                                              rsp_valid, rsp_err, rsp_timeout}), 64'(0));
                    check("zero_paddr",  i, 64'(tim_paddr),  64'(0));
                    check("zero_pwdata", i, 64'(tim_pwdata), 64'(0));
                    check("zero_pstrb",  i, 64'(tim_pstrb),  64'(0));
                    check("zero_rdata",  i, 64'(rsp_rdata),  64'(0));
                end else begin
                    check($sformatf("%s_ctl", c.ph.name()), i,
                          64'({cmd_ready, tim_psel, tim_penable, rsp_valid}),
                          64'({c.x_cmd_ready, c.x_psel, c.x_penable, c.x_rsp_valid}));
                    if (c.x_apb) begin
                        check($sformatf("%s_addr", c.ph.name()), i,
                              64'({tim_pwrite, tim_paddr}), 64'({c.x_pwrite, c.x_paddr}));
                        check($sformatf("%s_pwdata", c.ph.name()), i, 64'(tim_pwdata), 64'(c.x_pwdata));
                        check($sformatf("%s_pstrb", c.ph.name()), i, 64'(tim_pstrb), 64'(c.x_pstrb));
                    end
                    if (c.x_rsp) begin
                        check("resp_err", i, 64'({rsp_err, rsp_timeout}), 64'({c.x_err, c.x_timeout}));
                        check("resp_rdata", i, 64'(rsp_rdata), 64'(c.x_rdata));
                    end
                end
            end
            if (c.txn >= 0) begin
                if (tim_psel)    psel_n[c.txn]++;
                if (tim_penable) pen_n[c.txn]++;
                if (rsp_valid) begin
                    rsp_n[c.txn]++;
                    if (first_rsp[c.txn] < 0) first_rsp[c.txn] = i;
                    obs_err[c.txn]   = rsp_err;
                    obs_to[c.txn]    = rsp_timeout;
                    obs_rdata[c.txn] = rsp_rdata;
                end
            end
            sys_rst     = c.rst;
            cmd_valid   = c.cmd_valid;
            cmd_write   = c.cmd_write;
            cmd_addr    = c.cmd_addr;
            cmd_wdata   = c.cmd_wdata;
            cmd_strb    = c.cmd_strb;
            rsp_ready   = c.rsp_ready;
            tim_pready  = c.pready;
            tim_pslverr = c.pslverr;
            tim_prdata  = c.prdata;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: schedule did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst = 1'b1;  cmd_valid = 1'b0;  cmd_write = 1'b0;  cmd_addr = '0;
        cmd_wdata = '0;  cmd_strb = '0;     rsp_ready = 1'b0;  tim_prdata = '0;
        tim_pready = 1'b0;  tim_pslverr = 1'b0;
        for (int t = 0; t < MAX_TXN; t++) begin
            accept_idx[t] = 0;  psel_n[t] = 0;  pen_n[t] = 0;  rsp_n[t] = 0;
            first_rsp[t] = -1;  obs_err[t] = 1'b0;  obs_to[t] = 1'b0;  obs_rdata[t] = '0;
        end

        //        wr    addr     wdata          strb  waits          slv   rdata          hold abort hv
        add_power_on_reset();
        add_txn(1'b1, 12'h004, 32'hA5A5_0001, 4'hF, 0,              1'b0, 32'h0,         0, 0, 1'b0); // 0
        add_txn(1'b0, 12'h010, 32'h0,         4'h0, 3,              1'b0, 32'h1234_5678, 0, 0, 1'b0); // 1
        add_txn(1'b0, 12'h020, 32'h0,         4'h0, TIMEOUT_CYC,    1'b0, 32'h0,         1, 0, 1'b0); // 2
        add_idle(1);
        add_txn(1'b1, 12'h006, 32'h1111_2222, 4'hF, 0,              1'b0, 32'h0,         0, 0, 1'b0); // 3
        add_txn(1'b1, 12'h008, 32'h3333_4444, 4'hC, 0,              1'b1, 32'h0,         5, 0, 1'b1); // 4
        add_txn(1'b0, 12'h00C, 32'h0,         4'h0, TIMEOUT_CYC-1,  1'b0, 32'hCAFE_F00D, 0, 0, 1'b0); // 5
        add_txn(1'b0, 12'h014, 32'h0,         4'h0, TIMEOUT_CYC,    1'b0, 32'h0,         0, 2, 1'b0); // 6
        add_txn(1'b0, 12'h018, 32'h0,         4'h0, 1,              1'b1, 32'h0BAD_BEEF, 0, 0, 1'b0); // 7
        add_txn(1'b0, 12'h001, 32'h0,         4'h0, 0,              1'b0, 32'h0,         2, 0, 1'b1); // 8
        add_txn(1'b1, 12'hFFC, 32'h5555_AAAA, 4'h5, 2,              1'b0, 32'h0,         0, 0, 1'b0); // 9
        add_idle(3);

        play();

        // Hand-computed pins for the key scenarios, independent of the schedule model.
        check("t0_psel_cycles", -1, 64'(psel_n[0]), 64'(2));
        check("t0_penable_cycles", -1, 64'(pen_n[0]), 64'(1));
        check("t0_rsp_latency", -1, 64'(first_rsp[0] - accept_idx[0]), 64'(3));
        check("t0_err_rdata", -1, 64'({obs_err[0], obs_rdata[0]}), 64'(0));
        check("t1_access_cycles", -1, 64'(pen_n[1]), 64'(4));
        check("t1_rsp_latency", -1, 64'(first_rsp[1] - accept_idx[1]), 64'(6));
        check("t1_rdata", -1, 64'(obs_rdata[1]), 64'(32'h1234_5678));
        check("t2_access_cycles", -1, 64'(pen_n[2]), 64'(16));
        check("t2_err_timeout", -1, 64'({obs_err[2], obs_to[2]}), 64'(2'b11));
        check("t3_psel_cycles", -1, 64'(psel_n[3]), 64'(0));
        check("t3_rsp_latency", -1, 64'(first_rsp[3] - accept_idx[3]), 64'(1));
        check("t3_err_timeout", -1, 64'({obs_err[3], obs_to[3]}), 64'(2'b10));
        check("t4_rsp_hold_cycles", -1, 64'(rsp_n[4]), 64'(6));
        check("t4_psel_cycles", -1, 64'(psel_n[4]), 64'(2));
        check("t5_access_cycles", -1, 64'(pen_n[5]), 64'(16));
        check("t5_no_timeout_rdata", -1, 64'({obs_err[5], obs_to[5], obs_rdata[5]}), 64'(34'h0_CAFE_F00D));
        check("t6_no_response", -1, 64'(rsp_n[6]), 64'(0));
        check("t6_access_cycles", -1, 64'(pen_n[6]), 64'(2));
        check("t7_slverr_rdata", -1, 64'({obs_err[7], obs_rdata[7]}), 64'(33'h1_0000_0000));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_apb_master.md
TIMER_APB_MASTER -- requirements
Module: timer_apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16, maximum consecutive ACCESS cycles with pready low (range 2..255).
REQ-004 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- sys_clk  in  1  system clock, rising edge
- sys_rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  pslverr, misalignment or timeout
- rsp_timeout  out  1  error cause was timeout
- tim_psel, tim_penable, tim_pwrite  out  1 each  APB control
- tim_paddr  out  ADDR_W  APB address
- tim_pwdata  out  DATA_W  APB write data
- tim_pstrb  out  DATA_W/8  APB strobes
- tim_prdata  in  DATA_W  APB read data
- tim_pready  in  1  APB ready
- tim_pslverr  in  1  APB error

Function
REQ-006 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-007 cmd_ready SHALL be high only in IDLE; the command is accepted on the cycle cmd_valid and cmd_ready are both high.
REQ-008 On acceptance, addr, write, wdata and strb SHALL be latched, and the FSM SHALL go to SETUP next cycle (tim_psel=1, tim_penable=0).
REQ-009 SETUP SHALL always last exactly one cycle before going to ACCESS (tim_psel=1, tim_penable=1).
REQ-010 tim_paddr, tim_pwrite, tim_pwdata and tim_pstrb SHALL be stable from SETUP through the last ACCESS cycle.
REQ-011 tim_pstrb SHALL be 0 for reads, and tim_pwdata SHALL be 0 for reads.
REQ-012 In ACCESS with tim_pready=1, the block SHALL capture tim_prdata (reads only) and tim_pslverr, then go to RESP next cycle.
REQ-013 Minimum latency SHALL be: accept at T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3.
REQ-014 The timeout counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with tim_pready=0.
REQ-015 When the timeout counter reaches TIMEOUT_CYC, the block SHALL drop tim_psel/tim_penable next cycle, go to RESP, and set rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-016 If tim_pready=1 arrives on the same cycle the count would reach TIMEOUT_CYC, the block SHALL complete normally with no timeout.
REQ-017 A command with cmd_addr[1:0]≠0 SHALL NOT generate an APB transfer; the block SHALL go IDLE→RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0 at T+1.
REQ-018 In RESP, rsp_valid SHALL be 1 and the rsp_* outputs SHALL stay stable until rsp_ready=1; the block SHALL then go to IDLE next cycle.
REQ-019 Since cmd_ready=0 in RESP, back-to-back commands SHALL be spaced by at least one IDLE cycle.
REQ-020 tim_psel and tim_penable SHALL be 0 in IDLE and RESP.

Reset
REQ-021 While sys_rst=1, the state SHALL be IDLE, and all outputs SHALL be 0 (cmd_ready=0), including rsp_*, tim_* and the timeout counter.
REQ-022 The cycle after reset deasserts, cmd_ready SHALL be 1.
REQ-023 Reset asserted during SETUP, ACCESS or RESP SHALL abort the transfer with no response generated; tim_psel SHALL be 0 on the next clock edge.

Structure
REQ-024 Package timer_apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS/RESP), the default ADDR_W/DATA_W/TIMEOUT_CYC constants and the alignment mask.
REQ-025 The timeout counter SHALL be the sub-module apb_timeout_cnt, with clear, enable, limit and expired ports.
REQ-026 The FSM, command latch and response register SHALL reside in timer_apb_master.

Verification
REQ-027 Write addr 0x004, data 0xA5A5_0001, strb 0xF, pready=1 at first ACCESS -> psel high 2 cycles, penable 1 cycle, rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
REQ-028 Read addr 0x010, pready low 3 cycles, prdata=0x1234_5678 on the ready cycle -> ACCESS 4 cycles, rsp_rdata=0x1234_5678, pstrb=0 throughout.
REQ-029 Read with pready held 0 and TIMEOUT_CYC=16 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1.
REQ-030 Write addr 0x006 -> no psel ever, rsp_valid at T+1, rsp_err=1, rsp_timeout=0.
REQ-031 pslverr=1 with pready=1 -> rsp_err=1; then hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp stable, cmd_ready=0, no new psel.
REQ-032 Assert sys_rst in the 2nd ACCESS cycle -> psel=0 next edge, rsp_valid stays 0, cmd_ready=1 the cycle after release.
